// File: rtl/updown_wrap_monitor_if.sv
// Sample/status bundle between the 4-bit up/down counter side and the wrap monitor.
// The master drives the sampled value and enable; the slave returns direction, pulses and counts.
interface updown_wrap_monitor_if;
   logic [3:0] In;
   logic       En;
   logic [1:0] Dir;
   logic       Wu;
   logic       Wd;
   logic       Jmp;
   logic       Chg;
   logic [7:0] UpCnt;
   logic [7:0] DnCnt;
   logic       Thr;

   modport master (
      output In, En,
      input  Dir, Wu, Wd, Jmp, Chg, UpCnt, DnCnt, Thr
   );

   modport slave (
      input  In, En,
      output Dir, Wu, Wd, Jmp, Chg, UpCnt, DnCnt, Thr
   );
endinterface

// File: rtl/updown_wrap_monitor.sv
// Classifies each enabled counter sample as hold/up/down/jump against the previous one,
// tracks direction, pulses on wraps/jumps/reversals and keeps saturating wrap counts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DIR_IDLE  | no direction yet, after a jump, or hold run reached HOLD_LIM
// DIR_UP    | last non-hold step was +1 (mod 16)
// DIR_DOWN  | last non-hold step was -1 (mod 16)
module updown_wrap_monitor #(
   parameter int         HOLD_LIM = 4,
   parameter logic [3:0] TH       = 4'd12
) (
   input  logic               Clk,
   input  logic               C,
   updown_wrap_monitor_if.slave bus
);

   typedef enum logic [1:0] {
      DIR_IDLE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_e;

   localparam logic [3:0] HOLD_LIM_W = 4'(HOLD_LIM);
   localparam logic [4:0] HOLD_LIM_X = 5'(HOLD_LIM);

   dir_e       dir_q,     dir_d;
   logic [3:0] p_q,       p_d;
   logic       pr_q,      pr_d;
   logic [3:0] h_q,       h_d;
   logic       wu_q,      wu_d;
   logic       wd_q,      wd_d;
   logic       jmp_q,     jmp_d;
   logic       chg_q,     chg_d;
   logic [7:0] up_cnt_q,  up_cnt_d;
   logic [7:0] dn_cnt_q,  dn_cnt_d;
   logic       thr_q,     thr_d;

   logic [3:0] step;
   logic [4:0] h_inc;

   assign step  = bus.In - p_q;
   assign h_inc = {1'b0, h_q} + 5'd1;

   always_comb begin
      dir_d    = dir_q;
      p_d      = p_q;
      pr_d     = pr_q;
      h_d      = h_q;
      wu_d     = 1'b0;
      wd_d     = 1'b0;
      jmp_d    = 1'b0;
      chg_d    = 1'b0;
      up_cnt_d = up_cnt_q;
      dn_cnt_d = dn_cnt_q;
      thr_d    = thr_q;

      if (bus.En) begin
         p_d   = bus.In;
         thr_d = (bus.In >= TH);
         if (!pr_q) begin
            // priming sample only establishes the reference value
            pr_d = 1'b1;
         end else begin
            case (step)
               4'd0: begin
                  if (h_inc >= HOLD_LIM_X) begin
                     h_d   = HOLD_LIM_W;
                     dir_d = DIR_IDLE;
                  end else begin
                     h_d = h_inc[3:0];
                  end
               end
               4'd1: begin
                  h_d   = 4'd0;
                  dir_d = DIR_UP;
                  if (p_q == 4'hF) begin
                     wu_d = 1'b1;
                     if (up_cnt_q != 8'hFF) up_cnt_d = up_cnt_q + 8'd1;
                  end
               end
               4'hF: begin
                  h_d   = 4'd0;
                  dir_d = DIR_DOWN;
                  if (p_q == 4'h0) begin
                     wd_d = 1'b1;
                     if (dn_cnt_q != 8'hFF) dn_cnt_d = dn_cnt_q + 8'd1;
                  end
               end
               default: begin
                  h_d   = 4'd0;
                  dir_d = DIR_IDLE;
                  jmp_d = 1'b1;
               end
            endcase
            chg_d = ((dir_q == DIR_UP)   && (dir_d == DIR_DOWN)) ||
                    ((dir_q == DIR_DOWN) && (dir_d == DIR_UP));
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (C) begin
         dir_q    <= DIR_IDLE;
         p_q      <= 4'd0;
         pr_q     <= 1'b0;
         h_q      <= 4'd0;
         wu_q     <= 1'b0;
         wd_q     <= 1'b0;
         jmp_q    <= 1'b0;
         chg_q    <= 1'b0;
         up_cnt_q <= 8'd0;
         dn_cnt_q <= 8'd0;
         thr_q    <= 1'b0;
      end else begin
         dir_q    <= dir_d;
         p_q      <= p_d;
         pr_q     <= pr_d;
         h_q      <= h_d;
         wu_q     <= wu_d;
         wd_q     <= wd_d;
         jmp_q    <= jmp_d;
         chg_q    <= chg_d;
         up_cnt_q <= up_cnt_d;
         dn_cnt_q <= dn_cnt_d;
         thr_q    <= thr_d;
      end
   end

   assign bus.Dir   = dir_q;
   assign bus.Wu    = wu_q;
   assign bus.Wd    = wd_q;
   assign bus.Jmp   = jmp_q;
   assign bus.Chg   = chg_q;
   assign bus.UpCnt = up_cnt_q;
   assign bus.DnCnt = dn_cnt_q;
   assign bus.Thr   = thr_q;

endmodule

// File: tb/tb_updown_wrap_monitor.sv
// Bench for updown_wrap_monitor: directed scenarios plus random walks, every cycle
// compared against a behavioural model built from the step-classification rules.
module tb_updown_wrap_monitor;

   localparam int HL  = 4;
   localparam int THV = 12;

   logic Clk = 1'b0;
   logic C   = 1'b1;

   updown_wrap_monitor_if ifc ();

   updown_wrap_monitor #(.HOLD_LIM(HL), .TH(4'd12)) dut (
      .Clk (Clk),
      .C   (C),
      .bus (ifc.slave)
   );

   always #5 Clk = ~Clk;

   int checks   = 0;
   int failures = 0;

   // behavioural reference state
   int m_prev, m_pr, m_h, m_dir, m_up, m_dn;
   int m_wu, m_wd, m_jmp, m_chg, m_thr;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev = 0; m_pr = 0; m_h = 0; m_dir = 0; m_up = 0; m_dn = 0;
      m_wu = 0; m_wd = 0; m_jmp = 0; m_chg = 0; m_thr = 0;
   endtask

   task automatic model_step(input bit c, input bit en, input int in);
      int diff, old;
      if (c) begin
         model_reset();
         return;
      end
      m_wu = 0; m_wd = 0; m_jmp = 0; m_chg = 0;
      if (!en) return;
      if (m_pr == 0) begin
         m_pr = 1;
      end else begin
         diff = (in - m_prev + 16) % 16;
         old  = m_dir;
         if (diff == 0) begin
            m_h = (m_h + 1 > HL) ? HL : m_h + 1;
            if (m_h == HL) m_dir = 0;
         end else if (diff == 1) begin
            m_h = 0; m_dir = 1;
            if (m_prev == 15) begin
               m_wu = 1;
               if (m_up < 255) m_up++;
            end
         end else if (diff == 15) begin
            m_h = 0; m_dir = 2;
            if (m_prev == 0) begin
               m_wd = 1;
               if (m_dn < 255) m_dn++;
            end
         end else begin
            m_h = 0; m_dir = 0; m_jmp = 1;
         end
         m_chg = ((old == 1 && m_dir == 2) || (old == 2 && m_dir == 1)) ? 1 : 0;
      end
      m_prev = in;
      m_thr  = (in >= THV) ? 1 : 0;
   endtask

   task automatic cyc(input bit c, input bit en, input int in);
      C      = c;
      ifc.En = en;
      ifc.In = 4'(in);
      @(posedge Clk);
      model_step(c, en, in);
      #1;
      chk("Dir",   int'(ifc.Dir),   m_dir);
      chk("Wu",    int'(ifc.Wu),    m_wu);
      chk("Wd",    int'(ifc.Wd),    m_wd);
      chk("Jmp",   int'(ifc.Jmp),   m_jmp);
      chk("Chg",   int'(ifc.Chg),   m_chg);
      chk("UpCnt", int'(ifc.UpCnt), m_up);
      chk("DnCnt", int'(ifc.DnCnt), m_dn);
      chk("Thr",   int'(ifc.Thr),   m_thr);
   endtask

   initial begin
      int cur;
      int seq_up[5]   = '{13, 14, 15, 0, 1};
      int seq_rev[6]  = '{5, 6, 7, 6, 5, 4};
      int seq_dn[5]   = '{1, 0, 15, 14, 3};
      int seq_hold[7] = '{8, 9, 9, 9, 9, 9, 9};

      model_reset();
      ifc.In = 4'd0;
      ifc.En = 1'b0;

      // reset and prime
      cyc(1, 0, 0);
      cyc(1, 1, 7);
      chk("reset_dir", int'(ifc.Dir), 0);
      chk("reset_upcnt", int'(ifc.UpCnt), 0);
      cyc(0, 1, 3);
      chk("prime_jmp", int'(ifc.Jmp), 0);
      chk("prime_dir", int'(ifc.Dir), 0);

      foreach (seq_up[i]) cyc(0, 1, seq_up[i]);
      chk("upwrap_cnt", int'(ifc.UpCnt), 1);
      chk("upwrap_dir", int'(ifc.Dir), 1);

      foreach (seq_rev[i]) cyc(0, 1, seq_rev[i]);
      chk("rev_dir", int'(ifc.Dir), 2);

      foreach (seq_dn[i]) cyc(0, 1, seq_dn[i]);
      chk("load_jmp", int'(ifc.Jmp), 1);
      chk("load_dncnt", int'(ifc.DnCnt), 1);

      foreach (seq_hold[i]) cyc(0, 1, seq_hold[i]);
      chk("hold_dir", int'(ifc.Dir), 0);

      // En gating: inputs move, state must not
      for (int i = 0; i < 6; i++) cyc(0, 0, i * 5);
      cyc(0, 1, 10);
      chk("gate_jmp", int'(ifc.Jmp), 0);
      chk("gate_dir", int'(ifc.Dir), 1);

      // reset mid-operation then a far value: priming only
      cyc(1, 1, 2);
      cyc(0, 1, 14);
      chk("rearm_jmp", int'(ifc.Jmp), 0);

      // drive UpCnt into saturation
      cur = 14;
      for (int w = 0; w < 260 * 16; w++) begin
         cur = (cur + 1) % 16;
         cyc(0, 1, cur);
      end
      chk("sat_upcnt", int'(ifc.UpCnt), 255);
      while (cur != 15) begin
         cur = (cur + 1) % 16;
         cyc(0, 1, cur);
      end
      cyc(0, 1, 0);
      chk("sat_wu", int'(ifc.Wu), 1);
      chk("sat_hold", int'(ifc.UpCnt), 255);

      // random walk with occasional jumps, gaps and resets
      for (int i = 0; i < 1500; i++) begin
         int r, c, en;
         r  = $urandom_range(0, 99);
         c  = ($urandom_range(0, 99) < 2) ? 1 : 0;
         en = ($urandom_range(0, 99) < 80) ? 1 : 0;
         if (r < 35)      cur = (cur + 1) % 16;
         else if (r < 65) cur = (cur + 15) % 16;
         else if (r < 90) cur = cur;
         else             cur = $urandom_range(0, 15);
         cyc(c[0], en[0], cur);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
